// File: rtl/cordic_share_arbiter.sv
// cordic_share_arbiter: round-robin sharing of one CORDIC pipeline between two requesters with per-requester result FIFOs
module cordic_share_arbiter #(
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mode,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req0_angle,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mode,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [15:0] req1_angle,
  output logic        res0_valid,
  input  logic        res0_ready,
  output logic [15:0] res0_a,
  output logic [15:0] res0_b,
  output logic        res1_valid,
  input  logic        res1_ready,
  output logic [15:0] res1_a,
  output logic [15:0] res1_b,
  output logic        cd_op_mode,
  output logic [15:0] cd_x,
  output logic [15:0] cd_y,
  output logic [15:0] cd_angle,
  input  logic [15:0] cd_x_or_phase,
  input  logic [15:0] cd_y_or_size,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(LATENCY + 1) + 1;

  logic               cur_mode_q, rr_ptr_q, switch_pending_q, pending_mode_q;
  logic [LATENCY-1:0] tag_v_q, tag_id_q;
  logic [IW-1:0]      inflight_q;
  logic [1:0]         rv, rm, rr, elig, push, pop, empty, full;
  logic [1:0][31:0]   head;
  logic               any, win, cap, cid;
  logic [31:0]        cap_data;

  assign rv = {req1_valid, req0_valid};
  assign rm = {req1_mode, req0_mode};
  assign rr = {res1_ready, res0_ready};

  // rr_ptr requester wins when eligible, otherwise the other one
  assign any        = |elig;
  assign win        = elig[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
  assign req0_ready = any & ~win;
  assign req1_ready = any & win;

  assign cd_op_mode = cur_mode_q;
  assign cd_x       = any ? (win ? req1_x : req0_x) : '0;
  assign cd_y       = any ? (win ? req1_y : req0_y) : '0;
  assign cd_angle   = any ? (win ? req1_angle : req0_angle) : '0;

  assign cap      = tag_v_q[LATENCY-1];
  assign cid      = tag_id_q[LATENCY-1];
  assign cap_data = {cd_x_or_phase, cd_y_or_size};

  assign res0_valid       = ~empty[0];
  assign res1_valid       = ~empty[1];
  assign {res0_a, res0_b} = head[0];
  assign {res1_a, res1_b} = head[1];
  assign busy             = |tag_v_q | ~&empty;

  // arbitration pointer, tag pipe, in-flight count and drain-then-switch mode control
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_mode_q       <= 1'b0;
      rr_ptr_q         <= 1'b0;
      switch_pending_q <= 1'b0;
      pending_mode_q   <= 1'b0;
      tag_v_q          <= '0;
      tag_id_q         <= '0;
      inflight_q       <= '0;
    end else begin
      tag_v_q    <= {tag_v_q[LATENCY-2:0], any};
      tag_id_q   <= {tag_id_q[LATENCY-2:0], any & win};
      inflight_q <= inflight_q + IW'(any) - IW'(cap);
      if (any) rr_ptr_q <= ~win;
      if (switch_pending_q && inflight_q == '0) begin
        cur_mode_q       <= pending_mode_q;
        switch_pending_q <= 1'b0;
      end else if (!switch_pending_q && rv[rr_ptr_q] && rm[rr_ptr_q] != cur_mode_q) begin
        switch_pending_q <= 1'b1;
        pending_mode_q   <= rm[rr_ptr_q];
      end
    end
  end

  for (genvar r = 0; r < 2; r++) begin : g_req
    logic [CW-1:0] credits_q;
    logic [AW:0]   wp_q, rp_q;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic          gnt;

    assign gnt      = any & (win == 1'(r));
    assign elig[r]  = reset & rv[r] & (credits_q != '0) & (rm[r] == cur_mode_q) & ~switch_pending_q;
    assign empty[r] = wp_q == rp_q;
    assign full[r]  = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
    assign push[r]  = cap & (cid == 1'(r));
    assign pop[r]   = ~empty[r] & rr[r];
    assign head[r]  = empty[r] ? '0 : mem_q[rp_q[AW-1:0]];

    // credits track free FIFO slots including results still in flight
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        credits_q <= CW'(FIFO_DEPTH);
        wp_q      <= '0;
        rp_q      <= '0;
      end else begin
        credits_q <= credits_q - CW'(gnt) + CW'(pop[r]);
        if (push[r]) wp_q <= wp_q + 1'b1;
        if (pop[r]) rp_q <= rp_q + 1'b1;
      end
    end

    // result storage needs no reset; validity comes from the pointers
    always_ff @(posedge clock) begin
      if (push[r]) mem_q[wp_q[AW-1:0]] <= cap_data;
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset) !(push[r] && full[r] && !pop[r]));
  end
endmodule
